// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch path, the load/store path and the
// shared single-port memory. The slave modport is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_rsp_valid;
  logic [DATA_W-1:0]     if_rsp_data;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [ADDR_W-1:0]     d_req_addr;
  logic                  d_req_we;
  logic [DATA_W/8-1:0]   d_req_be;
  logic [DATA_W-1:0]     d_req_wdata;
  logic                  d_rsp_valid;
  logic [DATA_W-1:0]     d_rsp_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_we;
  logic [DATA_W/8-1:0]   mem_req_be;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port, one
// transaction outstanding, data first with a bounded fetch-starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);
  localparam int BE_W = DATA_W / 8;

  // Handshakes: a request transfers in the cycle where valid and ready are
  // both high; requesters hold valid and fields stable until then.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RSP = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [3:0]          starve_cnt;
  logic                owner_d;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [BE_W-1:0]     lat_be;
  logic [DATA_W-1:0]   lat_wdata;
  logic                grant_if, grant_d, starved;
  logic                if_rsp_valid_q, d_rsp_valid_q;
  logic [DATA_W-1:0]   if_rsp_data_q, d_rsp_data_q;

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_req_valid && (!bus.d_req_valid || starved)) grant_if = 1'b1;
        else if (bus.d_req_valid)                               grant_d  = 1'b1;
        if (grant_if || grant_d) state_nxt = ISSUE;
      end
      ISSUE:    if (bus.mem_req_ready) state_nxt = WAIT_RSP;
      WAIT_RSP: if (bus.mem_rsp_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      owner_d        <= 1'b0;
      lat_addr       <= '0;
      lat_we         <= 1'b0;
      lat_be         <= '0;
      lat_wdata      <= '0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_data_q   <= '0;
    end else begin
      state          <= state_nxt;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if (grant_if || grant_d) begin
        owner_d   <= grant_d;
        lat_addr  <= grant_d ? bus.d_req_addr : bus.if_req_addr;
        lat_we    <= grant_d & bus.d_req_we;
        lat_be    <= grant_d ? bus.d_req_be : {BE_W{1'b1}};
        lat_wdata <= grant_d ? bus.d_req_wdata : '0;
      end
      // Only a data grant made while fetch is waiting counts toward starvation.
      if (grant_if)
        starve_cnt <= '0;
      else if (grant_d && !bus.if_req_valid)
        starve_cnt <= '0;
      else if (grant_d && !starved)
        starve_cnt <= starve_cnt + 4'd1;
      if (state == WAIT_RSP && bus.mem_rsp_valid) begin
        if (owner_d) begin
          d_rsp_valid_q <= 1'b1;
          d_rsp_data_q  <= lat_we ? '0 : bus.mem_rsp_data;
        end else begin
          if_rsp_valid_q <= 1'b1;
          if_rsp_data_q  <= bus.mem_rsp_data;
        end
      end
    end
  end

  // Readies are gated by rst_n so every output reads 0 while reset is held.
  assign bus.if_req_ready  = grant_if & rst_n;
  assign bus.d_req_ready   = grant_d & rst_n;
  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_req_addr  = lat_addr;
  assign bus.mem_req_we    = lat_we;
  assign bus.mem_req_be    = lat_be;
  assign bus.mem_req_wdata = lat_wdata;
  assign bus.if_rsp_valid  = if_rsp_valid_q;
  assign bus.if_rsp_data   = if_rsp_data_q;
  assign bus.d_rsp_valid   = d_rsp_valid_q;
  assign bus.d_rsp_data    = d_rsp_data_q;
  assign busy              = (state != IDLE);
  assign state_dbg         = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for starvation, stalls, reset and stray responses.
module tb_mem_port_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] state_dbg;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic        use_if;
    logic        use_d;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_rsp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.d_req_valid   = 1'b0;
    bus.d_req_addr    = '0;
    bus.d_req_we      = 1'b0;
    bus.d_req_be      = '0;
    bus.d_req_wdata   = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s_ctl", tag),
          32'({busy, bus.mem_req_valid, bus.if_rsp_valid, bus.d_rsp_valid,
               bus.if_req_ready, bus.d_req_ready, bus.mem_req_we}), 32'h0);
    check($sformatf("%s_if_data", tag), bus.if_rsp_data, 32'h0);
    check($sformatf("%s_d_data", tag), bus.d_rsp_data, 32'h0);
    check($sformatf("%s_addr", tag), bus.mem_req_addr, 32'h0);
    check($sformatf("%s_wdata", tag), bus.mem_req_wdata, 32'h0);
    check($sformatf("%s_be", tag), 32'(bus.mem_req_be), 32'h0);
    check($sformatf("%s_state", tag), 32'(state_dbg), 32'h0);
  endtask

  // One complete transaction: accept, immediate memory accept, response one
  // cycle later, strobe three cycles after accept, then data held.
  task automatic run_vector(input vec_t v, input string tag);
    @(posedge clk); #1;
    bus.if_req_valid = v.use_if;
    bus.if_req_addr  = v.if_addr;
    bus.d_req_valid  = v.use_d;
    bus.d_req_addr   = v.d_addr;
    bus.d_req_we     = v.d_we;
    bus.d_req_be     = v.d_be;
    bus.d_req_wdata  = v.d_wdata;
    @(negedge clk);
    check($sformatf("%s_ready", tag), 32'({bus.if_req_ready, bus.d_req_ready}),
          v.exp_d ? 32'h1 : 32'h2);
    @(posedge clk); #1;
    bus.if_req_valid  = 1'b0;
    bus.d_req_valid   = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    check($sformatf("%s_mvalid", tag), 32'(bus.mem_req_valid), 32'h1);
    check($sformatf("%s_maddr", tag), bus.mem_req_addr, v.exp_addr);
    check($sformatf("%s_mwe", tag), 32'(bus.mem_req_we), 32'(v.exp_we));
    check($sformatf("%s_mbe", tag), 32'(bus.mem_req_be), 32'(v.exp_be));
    if (v.exp_we) check($sformatf("%s_mwdata", tag), bus.mem_req_wdata, v.d_wdata);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = v.mem_rdata;
    @(negedge clk);
    check($sformatf("%s_wait", tag),
          32'({busy, bus.if_rsp_valid, bus.d_rsp_valid}), 32'h4);
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0BAD0BAD;
    @(negedge clk);
    check($sformatf("%s_strobe", tag),
          32'({busy, bus.if_rsp_valid, bus.d_rsp_valid}), v.exp_d ? 32'h1 : 32'h2);
    check($sformatf("%s_rdata", tag), v.exp_d ? bus.d_rsp_data : bus.if_rsp_data, v.exp_rsp);
    @(negedge clk);
    check($sformatf("%s_after", tag), 32'({bus.if_rsp_valid, bus.d_rsp_valid}), 32'h0);
    check($sformatf("%s_hold", tag), v.exp_d ? bus.d_rsp_data : bus.if_rsp_data, v.exp_rsp);
  endtask

  function automatic vec_t mk(input logic use_if, input logic use_d,
                              input logic [31:0] if_addr, input logic [31:0] d_addr,
                              input logic d_we, input logic [3:0] d_be,
                              input logic [31:0] d_wdata, input logic [31:0] mem_rdata,
                              input logic exp_d, input logic [31:0] exp_addr,
                              input logic exp_we, input logic [3:0] exp_be,
                              input logic [31:0] exp_rsp);
    vec_t v;
    v.use_if = use_if;   v.use_d = use_d;       v.if_addr = if_addr;
    v.d_addr = d_addr;   v.d_we = d_we;         v.d_be = d_be;
    v.d_wdata = d_wdata; v.mem_rdata = mem_rdata;
    v.exp_d = exp_d;     v.exp_addr = exp_addr; v.exp_we = exp_we;
    v.exp_be = exp_be;   v.exp_rsp = exp_rsp;
    return v;
  endfunction

  initial begin
    #200000;
    $display("timeout: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    logic exp_seq[10];
    logic got;

    // use_if use_d if_addr d_addr we be wdata mem_rdata | exp_d addr we be rsp
    vecs[0] = mk(1, 0, 32'h100, 32'h0,    0, 4'h0, 32'h0,        32'h00500093,
                 0, 32'h100,  0, 4'hF, 32'h00500093);
    vecs[1] = mk(0, 1, 32'h0,   32'h2000, 1, 4'h3, 32'hDEADBEEF, 32'h12345678,
                 1, 32'h2000, 1, 4'h3, 32'h0);
    vecs[2] = mk(0, 1, 32'h0,   32'h3004, 0, 4'hF, 32'h0,        32'hCAFEF00D,
                 1, 32'h3004, 0, 4'hF, 32'hCAFEF00D);
    vecs[3] = mk(1, 1, 32'h104, 32'h40,   0, 4'hF, 32'h0,        32'h11112222,
                 1, 32'h40,   0, 4'hF, 32'h11112222);
    vecs[4] = mk(1, 0, 32'h108, 32'h0,    0, 4'h0, 32'h0,        32'h33334444,
                 0, 32'h108,  0, 4'hF, 32'h33334444);
    vecs[5] = mk(1, 1, 32'h10C, 32'h44,   1, 4'hC, 32'hA5A5A5A5, 32'hFFFFFFFF,
                 1, 32'h44,   1, 4'hC, 32'h0);
    vecs[6] = mk(0, 1, 32'h0,   32'h48,   0, 4'h1, 32'h0,        32'h55AA55AA,
                 1, 32'h48,   0, 4'h1, 32'h55AA55AA);
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held valid: four data grants, then one forced fetch.
    @(posedge clk); #1;
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h300;
    bus.d_req_valid   = 1'b1;
    bus.d_req_addr    = 32'h80;
    bus.d_req_we      = 1'b0;
    bus.d_req_be      = 4'hF;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_data  = 32'h00001111;
    for (int k = 0; k < 10; k++) begin
      got = 1'b0;
      for (int t = 0; t < 6 && !got; t++) begin
        @(negedge clk);
        if (bus.if_req_ready || bus.d_req_ready) got = 1'b1;
      end
      check($sformatf("starve_grant%0d", k), 32'({bus.if_req_ready, bus.d_req_ready}),
            exp_seq[k] ? 32'h1 : 32'h2);
      @(posedge clk);
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
    end
    drive_idle();
    repeat (2) @(posedge clk);

    // Memory stalls for five cycles with a fetch waiting behind a store.
    #1;
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b1;
    bus.d_req_addr  = 32'h5550;
    bus.d_req_be    = 4'h6;
    bus.d_req_wdata = 32'h0BADF00D;
    @(negedge clk);
    check("stall_accept", 32'({bus.if_req_ready, bus.d_req_ready}), 32'h1);
    @(posedge clk); #1;
    bus.d_req_valid  = 1'b0;
    bus.d_req_wdata  = 32'h0;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h400;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_ctl", i),
            32'({bus.mem_req_valid, busy, bus.if_req_ready, bus.d_req_ready}), 32'hC);
      check($sformatf("stall%0d_addr", i), bus.mem_req_addr, 32'h5550);
      check($sformatf("stall%0d_we_be", i), 32'({bus.mem_req_we, bus.mem_req_be}), 32'h16);
      check($sformatf("stall%0d_wdata", i), bus.mem_req_wdata, 32'h0BADF00D);
    end
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    bus.if_req_valid  = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h77777777;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stall_ack", 32'({bus.if_rsp_valid, bus.d_rsp_valid}), 32'h1);
    check("stall_ack_data", bus.d_rsp_data, 32'h0);

    // Reset while waiting for the response, then a stray response in IDLE.
    @(posedge clk); #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h500;
    @(posedge clk); #1;
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    check("pre_reset_state", 32'(state_dbg), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h00000BAD;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stray_rsp", 32'({busy, bus.if_rsp_valid, bus.d_rsp_valid}), 32'h0);
    check("stray_data", bus.if_rsp_data, 32'h0);
    v = mk(1, 0, 32'h600, 32'h0, 0, 4'h0, 32'h0, 32'h00A00113,
           0, 32'h600, 0, 4'hF, 32'h00A00113);
    run_vector(v, "post_reset");

    // A response during ISSUE is ignored; only the later one is delivered.
    @(posedge clk); #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h700;
    @(negedge clk);
    check("early_accept", 32'({bus.if_req_ready, bus.d_req_ready}), 32'h2);
    @(posedge clk); #1;
    bus.if_req_valid  = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hBAD0BAD0;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("early_ignored", 32'({state_dbg, bus.mem_req_valid, bus.if_rsp_valid}), 32'h6);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h600D600D;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_strobe", 32'({bus.if_rsp_valid, bus.d_rsp_valid}), 32'h2);
    check("late_data", bus.if_rsp_data, 32'h600D600D);
    @(negedge clk);
    check("late_single", 32'({busy, bus.if_rsp_valid, bus.d_rsp_valid}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch path and the load/store data path of the RV32I core.
- Accepts one request at a time from either requester over valid/ready handshakes and issues it to the memory port.
- Waits for the memory response and returns it to the owning requester.
- Data accesses have priority; a starvation guard guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of all request ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, maximum consecutive data grants issued while a fetch request is pending; range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch response strobe, one cycle
- if_rsp_data  out  DATA_W  fetched instruction word
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  load/store address
- d_req_we  in  1  1 = store, 0 = load
- d_req_be  in  DATA_W/8  store byte enables
- d_req_wdata  in  DATA_W  store data
- d_rsp_valid  out  1  data response strobe, one cycle; also the store acknowledge
- d_rsp_data  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  memory address
- mem_req_we  out  1  memory write enable
- mem_req_be  out  DATA_W/8  memory byte enables
- mem_req_wdata  out  DATA_W  memory write data
- mem_rsp_valid  in  1  memory response valid, one per accepted request, reads and writes
- mem_rsp_data  in  DATA_W  memory read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: all state is on the single clk. Reset is asynchronous and active-low on rst_n.
- Reset state: state = IDLE, starve_cnt = 0, owner = 0, latched request fields = 0.
- Reset outputs: every output is 0, including if_rsp_data and d_rsp_data.
- Reset mid-transaction: the pending transaction is dropped. Any late mem_rsp_valid arriving in IDLE is ignored and produces no rsp strobe.
- FSM states: IDLE, ISSUE, WAIT_RSP. At most one transaction is outstanding.
- IDLE:
  - The grant is decided combinationally. Fetch wins if if_req_valid is high and (d_req_valid is low or starve_cnt == STARVE_LIMIT). Otherwise data wins if d_req_valid is high.
  - The winner's ready is 1 and the loser's ready is 0.
  - On the handshake: latch addr/we/be/wdata and owner, then go to ISSUE.
  - Fetch grants drive we=0 and be=all-ones.
  - No valid input: remain in IDLE.
- ISSUE:
  - mem_req_valid = 1; all mem_req_* fields are driven from the latches and stay stable until mem_req_ready.
  - On mem_req_ready: go to WAIT_RSP.
  - mem_rsp_valid in this state is a protocol violation and is ignored.
- WAIT_RSP:
  - On mem_rsp_valid: go to IDLE next cycle.
  - The owner's rsp_valid pulses high exactly one cycle later, registered.
  - rsp_data = mem_rsp_data for fetch and for data loads; 0 for data stores.
  - rsp_data holds its value until the next response.
- Both ready outputs are 0 in ISSUE and WAIT_RSP.
- Latency: request accepted at cycle N -> mem_req_valid at N+1. If mem_req_ready is high at N+1 and mem_rsp_valid at N+2, the rsp strobe occurs at N+3. The earliest new accept is also N+3, i.e. the cycle the FSM re-enters IDLE.
- Starvation counter, updated only on an IDLE grant:
  - Data grant while if_req_valid is high: starve_cnt += 1, saturating at STARVE_LIMIT.
  - Fetch grant: starve_cnt = 0.
  - Data grant while if_req_valid is low: starve_cnt = 0.
- Simultaneous valids with starve_cnt < STARVE_LIMIT: data wins.
- Requests whose valid drops before the handshake are not issued. Requesters are expected to hold valid until ready.

Test Plan:
1. Reset then fetch only: if_req_addr = 0x100; memory ready immediately, responds with 0x00500093 next cycle -> if_rsp_valid at cycle 3 after accept, data 0x00500093. d_rsp_valid stays 0.
2. Store: d_req_we = 1, addr = 0x2000, be = 0x3, wdata = 0xDEADBEEF -> mem_req shows identical fields; after ack, d_rsp_valid pulses with d_rsp_data = 0.
3. Fetch and data both held valid continuously, STARVE_LIMIT = 4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
4. mem_req_ready held low for 5 cycles -> mem_req_valid and all fields stable throughout; busy = 1; both readies = 0.
5. rst_n asserted in WAIT_RSP, released, then a stray mem_rsp_valid -> all outputs immediately 0; no rsp strobe; the next fetch completes normally.
6. mem_rsp_valid pulse during ISSUE with mem_req_ready low -> ignored; the response after the handshake is the only one delivered.
